// File: rtl/controlador_gray_if.sv
// Bus between the test controller / Gray counter and the controlador_gray sequencer.
interface controlador_gray_if #(
    parameter int unsigned ANCHO = 5
);
    localparam int unsigned AN_N = ANCHO + 1;

    logic            inicio;
    logic            abortar;
    logic [AN_N-1:0] num_cuentas;
    logic [ANCHO-1:0] salida_gray;
    logic            enable;
    logic            reset_cnt;
    logic            ocupado;
    logic            listo;
    logic            error;
    logic [AN_N-1:0] conteo_err;

    // Controller / counter side.
    modport master (
        output inicio, abortar, num_cuentas, salida_gray,
        input  enable, reset_cnt, ocupado, listo, error, conteo_err
    );

    // Sequencer side.
    modport slave (
        input  inicio, abortar, num_cuentas, salida_gray,
        output enable, reset_cnt, ocupado, listo, error, conteo_err
    );
endinterface

// File: rtl/controlador_gray.sv
// Sequencer and checker for a Gray counter: clears it, enables it for N clocks,
// compares every observed value against a binary-to-Gray reference, reports errors.
module controlador_gray #(
    parameter int unsigned ANCHO = 5
) (
    input  logic               clk,
    input  logic               reset,
    controlador_gray_if.slave  bus
);
    localparam int unsigned AN_N = ANCHO + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LIMPIAR = 3'd1,
        ESPERA  = 3'd2,
        CONTAR  = 3'd3,
        FIN     = 3'd4,
        LISTO   = 3'd5
    } estado_t;

    estado_t          estado;
    estado_t          estado_sig;
    logic [ANCHO-1:0] cnt_bin;
    logic [AN_N-1:0]  restantes;
    logic             enable_d;
    logic             reset_cnt_d;
    logic             ocupado_d;
    logic             listo_d;
    logic [ANCHO-1:0] gray_ref_c;
    logic             chequear_c;
    logic             fallo_c;
    logic             aceptar_c;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) estado <= IDLE;
        else       estado <= estado_sig;
    end

    // Next-state logic; an abort beats every other exit from LIMPIAR/ESPERA/CONTAR.
    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE:    if (bus.inicio) estado_sig = LIMPIAR;
            LIMPIAR: estado_sig = bus.abortar ? IDLE : ESPERA;
            ESPERA: begin
                if (bus.abortar)             estado_sig = IDLE;
                else if (restantes != '0)    estado_sig = CONTAR;
                else                         estado_sig = FIN;
            end
            CONTAR: begin
                if (bus.abortar)                  estado_sig = IDLE;
                else if (restantes == AN_N'(1))   estado_sig = FIN;
            end
            FIN:     estado_sig = LISTO;
            LISTO:   estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase
    end

    // Moore output decode of the upcoming state, so the registered outputs track the state register.
    always_comb begin
        enable_d    = 1'b0;
        reset_cnt_d = 1'b0;
        ocupado_d   = 1'b0;
        listo_d     = 1'b0;
        ocupado_d   = (estado_sig != IDLE);
        reset_cnt_d = (estado_sig == LIMPIAR);
        enable_d    = (estado_sig == CONTAR);
        listo_d     = (estado_sig == LISTO);
    end

    // Reference comparison; aborted cycles leave the error state untouched.
    always_comb begin
        aceptar_c  = (estado == IDLE) && bus.inicio;
        gray_ref_c = cnt_bin ^ (cnt_bin >> 1);
        chequear_c = ((estado == ESPERA) || (estado == CONTAR) || (estado == FIN))
                     && !(bus.abortar && (estado != FIN));
        fallo_c    = chequear_c && (bus.salida_gray != gray_ref_c);
    end

    // Datapath: latched count, binary reference, sticky error and saturating mismatch count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            restantes      <= '0;
            cnt_bin        <= '0;
            bus.error      <= 1'b0;
            bus.conteo_err <= '0;
        end else if (aceptar_c) begin
            restantes      <= bus.num_cuentas;
            cnt_bin        <= '0;
            bus.error      <= 1'b0;
            bus.conteo_err <= '0;
        end else begin
            if (estado == CONTAR) begin
                cnt_bin   <= cnt_bin + ANCHO'(1);
                restantes <= restantes - AN_N'(1);
            end
            if (fallo_c) begin
                bus.error <= 1'b1;
                if (bus.conteo_err != '1) bus.conteo_err <= bus.conteo_err + AN_N'(1);
            end
        end
    end

    // Registered control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.enable    <= 1'b0;
            bus.reset_cnt <= 1'b0;
            bus.ocupado   <= 1'b0;
            bus.listo     <= 1'b0;
        end else begin
            bus.enable    <= enable_d;
            bus.reset_cnt <= reset_cnt_d;
            bus.ocupado   <= ocupado_d;
            bus.listo     <= listo_d;
        end
    end
endmodule

// File: tb/tb_controlador_gray.sv
// Directed bench for controlador_gray with a behavioural 5-bit Gray counter attached.
module tb_controlador_gray;
    logic clk = 1'b0;
    logic reset;
    logic forzar;
    logic [4:0] cnt_mod;
    int checks = 0;
    int failures = 0;

    controlador_gray_if #(.ANCHO(5)) bus ();

    controlador_gray #(.ANCHO(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Counter under check; forzar pins bit 0 low to emulate a stuck bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              cnt_mod <= '0;
        else if (bus.reset_cnt) cnt_mod <= '0;
        else if (bus.enable)    cnt_mod <= cnt_mod + 5'd1;
    end
    assign bus.salida_gray = (cnt_mod ^ (cnt_mod >> 1)) & (forzar ? 5'b11110 : 5'b11111);

    task automatic chequear(input string tag, input int obs, input int esp);
        checks++;
        if (obs != esp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    // One run: pulse inicio, try a spurious inicio with a new count while busy, observe N+12 cycles.
    task automatic transaccion(input int n, output int t_listo, output int n_listo,
                               output int n_en, output int n_rc, output int g_fin,
                               output int err_fin, output int cerr_fin);
        t_listo = -1; n_listo = 0; n_en = 0; n_rc = 0; g_fin = -1; err_fin = -1; cerr_fin = -1;
        @(posedge clk); #1;
        bus.num_cuentas = 6'(n);
        bus.inicio = 1'b1;
        for (int k = 1; k <= n + 12; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.inicio = 1'b0;
            if (k == 2) begin bus.inicio = 1'b1; bus.num_cuentas = 6'd3; end
            if (k == 3) bus.inicio = 1'b0;
            if (bus.enable)    n_en++;
            if (bus.reset_cnt) n_rc++;
            if (bus.listo) begin
                n_listo++;
                if (t_listo < 0) begin
                    t_listo  = k;
                    g_fin    = int'(bus.salida_gray);
                    err_fin  = int'(bus.error);
                    cerr_fin = int'(bus.conteo_err);
                end
            end
        end
    endtask

    int t_l, n_l, n_e, n_r, g_f, e_f, c_f;

    initial begin
        reset = 1'b1; forzar = 1'b0;
        bus.inicio = 1'b0; bus.abortar = 1'b0; bus.num_cuentas = '0;
        repeat (2) @(posedge clk);
        #1;
        chequear("rst_enable",  int'(bus.enable), 0);
        chequear("rst_ocupado", int'(bus.ocupado), 0);
        chequear("rst_listo",   int'(bus.listo), 0);
        chequear("rst_rcnt",    int'(bus.reset_cnt), 0);
        chequear("rst_err",     int'(bus.error), 0);
        chequear("rst_cerr",    int'(bus.conteo_err), 0);
        reset = 1'b0;

        // 1: reset during CONTAR cycle 3 of N=10 with a faulty counter.
        forzar = 1'b1;
        @(posedge clk); #1;
        bus.num_cuentas = 6'd10; bus.inicio = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.inicio = 1'b0;
        end
        chequear("t1_pre_enable", int'(bus.enable), 1);
        chequear("t1_pre_cerr",   int'(bus.conteo_err), 2);
        reset = 1'b1;
        #1;
        chequear("t1_enable",  int'(bus.enable), 0);
        chequear("t1_ocupado", int'(bus.ocupado), 0);
        chequear("t1_cerr",    int'(bus.conteo_err), 0);
        chequear("t1_err",     int'(bus.error), 0);
        @(posedge clk); #1;
        reset = 1'b0; forzar = 1'b0;
        @(posedge clk); #1;
        chequear("t1_idle", int'(bus.ocupado), 0);

        // 2: N=5, correct counter.
        transaccion(5, t_l, n_l, n_e, n_r, g_f, e_f, c_f);
        chequear("t2_t_listo", t_l, 9);
        chequear("t2_n_listo", n_l, 1);
        chequear("t2_n_en",    n_e, 5);
        chequear("t2_n_rcnt",  n_r, 1);
        chequear("t2_g_fin",   g_f, 7);
        chequear("t2_err",     e_f, 0);
        chequear("t2_cerr",    c_f, 0);

        // 3: N=33 wraps 31->0; FIN expects gray(1).
        transaccion(33, t_l, n_l, n_e, n_r, g_f, e_f, c_f);
        chequear("t3_t_listo", t_l, 37);
        chequear("t3_n_en",    n_e, 33);
        chequear("t3_g_fin",   g_f, 1);
        chequear("t3_err",     e_f, 0);
        chequear("t3_cerr",    c_f, 0);

        // 4: bit 0 stuck low, N=4 -> two mismatches.
        forzar = 1'b1;
        transaccion(4, t_l, n_l, n_e, n_r, g_f, e_f, c_f);
        forzar = 1'b0;
        chequear("t4_t_listo", t_l, 8);
        chequear("t4_g_fin",   g_f, 6);
        chequear("t4_err",     e_f, 1);
        chequear("t4_cerr",    c_f, 2);

        // 6: N=0 straight to FIN; spurious inicio ignored; new inicio clears previous errors.
        transaccion(0, t_l, n_l, n_e, n_r, g_f, e_f, c_f);
        chequear("t6_t_listo", t_l, 4);
        chequear("t6_n_listo", n_l, 1);
        chequear("t6_n_en",    n_e, 0);
        chequear("t6_g_fin",   g_f, 0);
        chequear("t6_err",     e_f, 0);
        chequear("t6_cerr",    c_f, 0);

        // 5: abort in CONTAR cycle 2 of N=8.
        @(posedge clk); #1;
        bus.num_cuentas = 6'd8; bus.inicio = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.inicio = 1'b0;
        end
        chequear("t5_pre_enable", int'(bus.enable), 1);
        bus.abortar = 1'b1;
        @(posedge clk); #1;
        bus.abortar = 1'b0;
        chequear("t5_enable",  int'(bus.enable), 0);
        chequear("t5_ocupado", int'(bus.ocupado), 0);
        chequear("t5_rcnt",    int'(bus.reset_cnt), 0);
        n_l = 0;
        for (int k = 0; k < 14; k++) begin
            if (bus.listo) n_l++;
            @(posedge clk); #1;
        end
        chequear("t5_n_listo", n_l, 0);
        chequear("t5_cerr",    int'(bus.conteo_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
